prach_pack: RTL and testbench
=============================

# prach_pack

Packs the decimated PRACH sample stream from the DDC (`prach_ddc`) into 128-bit per-channel beats and presents them as an Avalon-ST packet stream with backpressure on `clk_dsp`. It sits between the DDC output and the clock-domain crossing toward the eth/xran framer. It absorbs framer stalls in a local FIFO and reports, rather than hides, overflow.

## Interface
Parameters:
- `PKT_BEATS`, 12: beats per packet per channel; 8 words/beat, so 96 words per packet.
- `FIFO_DEPTH`, 64: output FIFO depth in beats; must be a power of 2.

Ports:
- `clk_dsp`  in  1  DSP clock; the only clock.
- `rst_dsp_n`  in  1  reset, asynchronous, active-low.
- `din_dq`  in  16  DDC output word (I/Q interleaved, opaque here).
- `din_dv`  in  1  `din_dq` valid.
- `din_chn`  in  8  channel = cc*8+ant; legal range 0..23.
- `sync_in`  in  1  1-cycle symbol/frame alignment pulse from DDC.
- `avst_source_data`  out  128  packed beat; word 0 in [15:0], word 7 in [127:112].
- `avst_source_valid`  out  1  beat valid.
- `avst_source_channel`  out  16  {8'd0, channel}.
- `avst_source_startofpacket`  out  1  first beat of a channel packet.
- `avst_source_endofpacket`  out  1  last beat of a channel packet.
- `avst_source_ready`  in  1  sink ready.
- `stat_clr`  in  1  clears sticky status.
- `stat_overflow`  out  1  sticky: a beat was dropped because the FIFO was full.
- `stat_badchn`  out  1  sticky: a `din_dv` word arrived with `din_chn` > 23.

## Operation
- Per-channel state, 24 entries:
  - word index `widx` (0..7),
  - beat index `bidx` (0..PKT_BEATS-1),
  - 7-word partial accumulator (112 bits).
- On `din_dv` with a legal channel:
  - if `widx` < 7, store the word at slot `widx` and increment `widx`;
  - if `widx` == 7, form the beat {din_dq, acc[111:0]}, set `widx` to 0, and push to the FIFO with sop = (`bidx`==0) and eop = (`bidx`==PKT_BEATS-1); `bidx` wraps PKT_BEATS-1 → 0.
- Illegal channel (> 23): the word is discarded, no state changes, and `stat_badchn` is set.
- `sync_in`: clears `widx`/`bidx` of all channels; partial accumulators are abandoned and not emitted.
  - If `sync_in` and `din_dv` occur in the same cycle, the sync is applied first and the word becomes word 0 of beat 0.
- Beats from different channels may interleave on the output. Packets of one channel are never reordered. The downstream framer demuxes by `avst_source_channel`.
- FIFO full on push: the beat is dropped, `stat_overflow` is set, and that channel's `bidx`/`widx` still advance so that packet boundaries stay aligned to `sync_in`.
- Simultaneous push and pop when the FIFO is full: the pop frees a slot and the push is accepted.
- `stat_clr` clears both sticky bits. If a set event occurs in the same cycle as `stat_clr`, the bit ends up set.

## Timing
- Reset: all outputs 0; FIFO empty; all `widx`/`bidx` = 0; accumulators don't-care.
- A beat pushed at cycle N+1, where cycle N is the cycle word 7 is sampled, appears on the source at N+2 if the FIFO was empty (FWFT, registered output).
- Handshake:
  - a transfer occurs when `valid`&`ready`;
  - while `valid`&!`ready`, data/channel/sop/eop are held stable;
  - `valid` never depends combinationally on `ready`.
- Sustained throughput is 1 beat/cycle pop, far above the input rate of ≤1 word/cycle.
- Reset asserted mid-packet: the FIFO is flushed, all outputs go to 0 immediately, and the partial packet is lost. After release, output resumes at the next full beat.

## Structure
- Shared `prach_pkg` holds:
  - `NUM_ANT`=8, `NUM_CC`=3, `NUM_CHN`=24, `SAMPLE_W`=16;
  - the beat struct {data[127:0], chn[7:0], sop, eop}.
- Sub-module `prach_pack_fifo`: synchronous FWFT FIFO of the beat struct, exposing `full`/`empty`/`count`.
- Per-channel state lives in register arrays indexed by `din_chn`. Only one channel is updated per cycle.

## Test plan
- Single channel 5, 96 words 0..95 after `sync_in`, ready=1 → 12 beats, chn=5; beat 0 data words 0..7 with sop=1; beat 11 words 88..95 with eop=1.
- Channels 0..23 round-robin, 8 words each (value = chn*256+k) → 24 beats, one per channel, each carrying correct words, all sop=1.
- ready=0 until 70 beats are generated with `FIFO_DEPTH`=64 → 64 beats retained, `stat_overflow`=1, 6 beats missing. After ready=1, output shows sop/eop still at 12-beat boundaries.
- `sync_in` after 3 words on channel 2, then 8 new words → one beat containing only the 8 new words, sop=1; the first 3 words are never emitted.
- `din_chn`=30 with dv → no output, `stat_badchn`=1; `stat_clr` → 0.
- Assert `rst_dsp_n`=0 while `valid`&!`ready` mid-packet → all outputs 0 asynchronously; after release the first beat is sop of a fresh packet.

Source files
------------

// File: rtl/prach_pkg.sv
// Shared types and constants for the PRACH packing path.
// Beat layout: word 0 in data[15:0], word 7 in data[127:112].
package prach_pkg;

    localparam int NUM_ANT  = 8;
    localparam int NUM_CC   = 3;
    localparam int NUM_CHN  = NUM_ANT * NUM_CC;
    localparam int SAMPLE_W = 16;

    typedef struct packed {
        logic [127:0] data;
        logic [7:0]   chn;
        logic         sop;
        logic         eop;
    } beat_t;

endpackage

// File: rtl/prach_pack_fifo.sv
// First-word-fall-through beat FIFO; head entry is visible while not empty.
// A pop and a push in the same cycle are both accepted even when full.
module prach_pack_fifo
    import prach_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    wr_en,
    input  beat_t   wr_data,
    input  logic    rd_en,
    output beat_t   rd_data,
    output logic    full,
    output logic    empty,
    output logic [AW:0] count
);

    beat_t          mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic           do_rd;
    logic           do_wr;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_rd   = rd_en & ~empty;
    assign do_wr   = wr_en & (~full | do_rd);
    assign rd_data = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) wptr <= wptr + AW'(1);
            if (do_rd) rptr <= rptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/prach_pack.sv
// Packs per-channel DDC words into 128-bit beats and streams them as
// Avalon-ST packets through a local FIFO with sticky overflow/badchn flags.
module prach_pack
    import prach_pkg::*;
#(
    parameter int PKT_BEATS  = 12,
    parameter int FIFO_DEPTH = 64
) (
    input  logic         clk_dsp,
    input  logic         rst_dsp_n,
    input  logic [15:0]  din_dq,
    input  logic         din_dv,
    input  logic [7:0]   din_chn,
    input  logic         sync_in,
    output logic [127:0] avst_source_data,
    output logic         avst_source_valid,
    output logic [15:0]  avst_source_channel,
    output logic         avst_source_startofpacket,
    output logic         avst_source_endofpacket,
    input  logic         avst_source_ready,
    input  logic         stat_clr,
    output logic         stat_overflow,
    output logic         stat_badchn
);

    localparam int BW = (PKT_BEATS > 1) ? $clog2(PKT_BEATS) : 1;
    localparam int FW = $clog2(FIFO_DEPTH);

    logic [2:0]    widx [NUM_CHN];
    logic [BW-1:0] bidx [NUM_CHN];
    logic [111:0]  acc  [NUM_CHN];

    logic [4:0]    ci;
    logic          legal;
    logic          bad;
    logic [2:0]    cur_w;
    logic [BW-1:0] cur_b;
    logic          last_w;

    logic          pv;
    beat_t         pbeat;
    beat_t         head;
    logic          f_full;
    logic          f_empty;
    logic [FW:0]   unused_cnt;
    logic          pop;
    logic          drop;

    assign ci     = din_chn[4:0];
    assign legal  = din_dv & (din_chn < 8'(NUM_CHN));
    assign bad    = din_dv & ~legal;
    // A same-cycle sync makes this word slot 0 of beat 0.
    assign cur_w  = sync_in ? 3'd0 : widx[ci];
    assign cur_b  = sync_in ? '0 : bidx[ci];
    assign last_w = (cur_w == 3'd7);

    always_ff @(posedge clk_dsp or negedge rst_dsp_n) begin
        if (!rst_dsp_n) begin
            for (int i = 0; i < NUM_CHN; i++) begin
                widx[i] <= '0;
                bidx[i] <= '0;
            end
        end else begin
            if (sync_in) begin
                for (int i = 0; i < NUM_CHN; i++) begin
                    widx[i] <= '0;
                    bidx[i] <= '0;
                end
            end
            if (legal) begin
                if (last_w) begin
                    widx[ci] <= '0;
                    if (cur_b == BW'(PKT_BEATS - 1)) bidx[ci] <= '0;
                    else                             bidx[ci] <= cur_b + BW'(1);
                end else begin
                    widx[ci] <= cur_w + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_dsp) begin
        if (legal && !last_w) begin
            for (int k = 0; k < 7; k++) begin
                if (cur_w == 3'(k)) acc[ci][16*k +: 16] <= din_dq;
            end
        end
    end

    always_ff @(posedge clk_dsp or negedge rst_dsp_n) begin
        if (!rst_dsp_n) begin
            pv    <= 1'b0;
            pbeat <= '0;
        end else begin
            pv <= legal & last_w;
            if (legal && last_w) begin
                pbeat.data <= {din_dq, acc[ci]};
                pbeat.chn  <= din_chn;
                pbeat.sop  <= (cur_b == '0);
                pbeat.eop  <= (cur_b == BW'(PKT_BEATS - 1));
            end
        end
    end

    prach_pack_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk_dsp),
        .rst_n   (rst_dsp_n),
        .wr_en   (pv),
        .wr_data (pbeat),
        .rd_en   (avst_source_ready),
        .rd_data (head),
        .full    (f_full),
        .empty   (f_empty),
        .count   (unused_cnt)
    );

    assign pop  = ~f_empty & avst_source_ready;
    assign drop = pv & f_full & ~pop;

    // Head fields are gated so every output reads 0 while the FIFO is empty.
    assign avst_source_valid         = ~f_empty;
    assign avst_source_data          = f_empty ? '0 : head.data;
    assign avst_source_channel       = f_empty ? '0 : {8'd0, head.chn};
    assign avst_source_startofpacket = ~f_empty & head.sop;
    assign avst_source_endofpacket   = ~f_empty & head.eop;

    always_ff @(posedge clk_dsp or negedge rst_dsp_n) begin
        if (!rst_dsp_n) begin
            stat_overflow <= 1'b0;
            stat_badchn   <= 1'b0;
        end else begin
            stat_overflow <= drop | (stat_overflow & ~stat_clr);
            stat_badchn   <= bad  | (stat_badchn & ~stat_clr);
        end
    end

endmodule

// File: tb/tb_prach_pack.sv
// Directed bench for prach_pack with a queue-based packet model
// and literal checks on selected beats.
module tb_prach_pack;
    import prach_pkg::*;

    logic         clk = 1'b0;
    logic         rst_dsp_n = 1'b0;
    logic [15:0]  din_dq = '0;
    logic         din_dv = 1'b0;
    logic [7:0]   din_chn = '0;
    logic         sync_in = 1'b0;
    logic [127:0] avst_source_data;
    logic         avst_source_valid;
    logic [15:0]  avst_source_channel;
    logic         avst_source_startofpacket;
    logic         avst_source_endofpacket;
    logic         avst_source_ready = 1'b1;
    logic         stat_clr = 1'b0;
    logic         stat_overflow;
    logic         stat_badchn;

    always #5 clk = ~clk;

    prach_pack #(.PKT_BEATS(12), .FIFO_DEPTH(64)) dut (
        .clk_dsp                   (clk),
        .rst_dsp_n                 (rst_dsp_n),
        .din_dq                    (din_dq),
        .din_dv                    (din_dv),
        .din_chn                   (din_chn),
        .sync_in                   (sync_in),
        .avst_source_data          (avst_source_data),
        .avst_source_valid         (avst_source_valid),
        .avst_source_channel       (avst_source_channel),
        .avst_source_startofpacket (avst_source_startofpacket),
        .avst_source_endofpacket   (avst_source_endofpacket),
        .avst_source_ready         (avst_source_ready),
        .stat_clr                  (stat_clr),
        .stat_overflow             (stat_overflow),
        .stat_badchn               (stat_badchn)
    );

    int npass = 0;
    int nchk  = 0;

    beat_t       exp_q [$];
    beat_t       log_q [$];
    logic [15:0] mw [NUM_CHN][$];
    int          mb [NUM_CHN];

    task automatic chk(input string nm, input logic [159:0] act,
                       input logic [159:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h required %h", nm, act, exp);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NUM_CHN; i++) begin
            mw[i].delete();
            mb[i] = 0;
        end
    endfunction

    // Packet model: 8 words per beat, 12 beats per packet, 64-beat buffer.
    function automatic void model_word(input int c, input logic [15:0] d,
                                       input logic s);
        beat_t b;
        if (s) model_reset();
        if (c < NUM_CHN) begin
            mw[c].push_back(d);
            if (mw[c].size() == 8) begin
                b = '0;
                for (int i = 0; i < 8; i++) b.data[16*i +: 16] = mw[c][i];
                b.chn = 8'(c);
                b.sop = (mb[c] == 0);
                b.eop = (mb[c] == 11);
                mb[c] = (mb[c] + 1) % 12;
                if (exp_q.size() < 64) exp_q.push_back(b);
                mw[c].delete();
            end
        end
    endfunction

    task automatic word(input int c, input logic [15:0] d, input logic s);
        din_chn = 8'(c);
        din_dq  = d;
        din_dv  = 1'b1;
        sync_in = s;
        @(posedge clk);
        #1;
        din_dv  = 1'b0;
        sync_in = 1'b0;
        model_word(c, d, s);
    endtask

    task automatic pulse_sync();
        sync_in = 1'b1;
        @(posedge clk);
        #1;
        sync_in = 1'b0;
        model_reset();
    endtask

    task automatic pulse_clr();
        stat_clr = 1'b1;
        @(posedge clk);
        #1;
        stat_clr = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int i = 0;
        while (exp_q.size() != 0 && i < maxc) begin
            @(posedge clk);
            i++;
        end
        repeat (4) @(posedge clk);
        #1;
        chk("drain_empty", 160'(exp_q.size()), 160'(0));
    endtask

    always @(negedge clk) begin
        beat_t e;
        beat_t g;
        if (avst_source_valid && avst_source_ready) begin
            g.data = avst_source_data;
            g.chn  = avst_source_channel[7:0];
            g.sop  = avst_source_startofpacket;
            g.eop  = avst_source_endofpacket;
            log_q.push_back(g);
            if (exp_q.size() == 0) begin
                nchk++;
                $display("FAIL unexpected_beat: got chn %0d data %h required none",
                         avst_source_channel, avst_source_data);
            end else begin
                e = exp_q.pop_front();
                chk("beat",
                    160'({avst_source_data, avst_source_channel,
                          avst_source_startofpacket, avst_source_endofpacket}),
                    160'({e.data, 8'd0, e.chn, e.sop, e.eop}));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #22;
        chk("rst_valid", 160'(avst_source_valid), 160'(0));
        chk("rst_data", 160'(avst_source_data), 160'(0));
        chk("rst_chn", 160'(avst_source_channel), 160'(0));
        chk("rst_sopeop", 160'({avst_source_startofpacket,
                                avst_source_endofpacket}), 160'(0));
        chk("rst_stats", 160'({stat_overflow, stat_badchn}), 160'(0));
        @(posedge clk);
        #1;
        rst_dsp_n = 1'b1;

        // single channel, one full packet
        log_q.delete();
        for (int k = 0; k < 96; k++) word(5, 16'(k), k == 0);
        drain(200);
        chk("t1_count", 160'(log_q.size()), 160'(12));
        chk("t1_b0_data", 160'(log_q[0].data),
            160'(128'h0007_0006_0005_0004_0003_0002_0001_0000));
        chk("t1_b0_sop", 160'({log_q[0].chn, log_q[0].sop}), 160'({8'd5, 1'b1}));
        chk("t1_b11_data", 160'(log_q[11].data),
            160'(128'h005F_005E_005D_005C_005B_005A_0059_0058));
        chk("t1_b11_eop", 160'(log_q[11].eop), 160'(1));

        // all channels, word-interleaved
        log_q.delete();
        for (int k = 0; k < 8; k++)
            for (int c = 0; c < NUM_CHN; c++)
                word(c, 16'(c * 256 + k), (c == 0) && (k == 0));
        drain(200);
        chk("t2_count", 160'(log_q.size()), 160'(24));
        chk("t2_b0_data", 160'(log_q[0].data),
            160'(128'h0007_0006_0005_0004_0003_0002_0001_0000));
        chk("t2_b23_chn", 160'({log_q[23].chn, log_q[23].sop}),
            160'({8'd23, 1'b1}));
        chk("t2_b23_w", 160'({log_q[23].data[127:112], log_q[23].data[15:0]}),
            160'({16'h1707, 16'h1700}));

        // overflow under backpressure
        avst_source_ready = 1'b0;
        log_q.delete();
        for (int n = 0; n < 560; n++) word(7, 16'(n), n == 0);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_model_kept", 160'(exp_q.size()), 160'(64));
        chk("t3_overflow", 160'(stat_overflow), 160'(1));
        chk("t3_valid_held", 160'(avst_source_valid), 160'(1));
        avst_source_ready = 1'b1;
        drain(300);
        chk("t3_count", 160'(log_q.size()), 160'(64));
        chk("t3_b60_sop", 160'({log_q[60].sop, log_q[59].eop}), 160'(2'b11));
        chk("t3_b63_w0", 160'(log_q[63].data[15:0]), 160'(16'h01F8));
        pulse_clr();
        chk("t3_ovf_clr", 160'(stat_overflow), 160'(0));
        log_q.delete();
        for (int n = 560; n < 576; n++) word(7, 16'(n), 1'b0);
        drain(100);
        chk("t3_tail_count", 160'(log_q.size()), 160'(2));
        chk("t3_tail_flags", 160'({log_q[0].sop, log_q[1].eop}), 160'(2'b01));
        chk("t3_tail_w0", 160'(log_q[1].data[15:0]), 160'(16'h0238));

        // sync abandons a partial beat
        log_q.delete();
        for (int k = 0; k < 3; k++) word(2, 16'(16'h0E00 + k), 1'b0);
        pulse_sync();
        for (int k = 0; k < 8; k++) word(2, 16'(16'h0A00 + k), 1'b0);
        drain(100);
        chk("t4_count", 160'(log_q.size()), 160'(1));
        chk("t4_data", 160'(log_q[0].data),
            160'(128'h0A07_0A06_0A05_0A04_0A03_0A02_0A01_0A00));
        chk("t4_sop", 160'({log_q[0].chn, log_q[0].sop}), 160'({8'd2, 1'b1}));

        // illegal channel
        log_q.delete();
        word(30, 16'hBEEF, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("t5_badchn", 160'(stat_badchn), 160'(1));
        chk("t5_no_out", 160'(log_q.size()), 160'(0));
        pulse_clr();
        chk("t5_clr", 160'(stat_badchn), 160'(0));
        stat_clr = 1'b1;
        word(31, 16'h1234, 1'b0);
        stat_clr = 1'b0;
        chk("t5_set_wins", 160'(stat_badchn), 160'(1));
        pulse_clr();
        chk("t5_clr2", 160'(stat_badchn), 160'(0));

        // asynchronous reset mid-packet while stalled
        avst_source_ready = 1'b0;
        log_q.delete();
        for (int k = 0; k < 24; k++) word(3, 16'(16'h0300 + k), 1'b0);
        for (int k = 0; k < 3; k++) word(4, 16'(16'h04F0 + k), 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_stalled", 160'(avst_source_valid), 160'(1));
        #3;
        rst_dsp_n = 1'b0;
        #1;
        chk("t6_rst_valid", 160'(avst_source_valid), 160'(0));
        chk("t6_rst_out", 160'({avst_source_data, avst_source_channel,
                                avst_source_startofpacket,
                                avst_source_endofpacket}), 160'(0));
        exp_q.delete();
        model_reset();
        @(posedge clk);
        #1;
        rst_dsp_n = 1'b1;
        avst_source_ready = 1'b1;
        for (int k = 0; k < 8; k++) word(4, 16'(16'h0400 + k), 1'b0);
        drain(100);
        chk("t6_count", 160'(log_q.size()), 160'(1));
        chk("t6_first", 160'({log_q[0].chn, log_q[0].sop, log_q[0].data[15:0]}),
            160'({8'd4, 1'b1, 16'h0400}));

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
